pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle RISC-V core, replacing the standalone +4 incrementer. It holds the architectural PC register and selects the next PC each cycle: sequential +4 (or +2 for compressed instructions), branch target, jump target or trap vector. It adds stall, a one-cycle redirect flush bubble, target-misalignment detection, an exception PC capture and a retired-instruction counter. It sits between the fetch address bus and the branch/jump resolution logic.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect
C_EXT, 0, 1 = compressed support: 2-byte alignment, +2 increment when inst_is_c
CNT_W, 32, width of the instret counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC; no retire
inst_is_c  input  1  current instruction is 16-bit; ignored when C_EXT=0
br_taken  input  1  conditional branch resolved taken
br_target  input  XLEN  branch target address
jmp  input  1  unconditional jump (JAL/JALR)
jmp_target  input  XLEN  jump target address
trap  input  1  external/illegal-instruction trap request
pc  output  XLEN  current PC (fetch address)
pc_plus  output  XLEN  combinational pc + increment (link value)
pc_valid  output  1  pc is a valid fetch address this cycle
misalign  output  1  one-cycle pulse: redirect target misaligned
epc  output  XLEN  PC of instruction that trapped or misaligned
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at a rising edge, any state): pc=RESET_VECTOR, pc_valid=0, misalign=0, epc=0, instret=0, state=BOOT. Reset overrides all other inputs.
- Increment inc = 2 when C_EXT=1 and inst_is_c=1, else 4. pc_plus = pc + inc, modulo 2^XLEN (0xFFFF_FFFC + 4 = 0x0). pc_plus is combinational, valid in every state.
- FSM states: BOOT, RUN, FLUSH.
- BOOT: pc held, pc_valid=0, inputs ignored; next state RUN.
- RUN: pc_valid=1. Per-cycle priority, highest first:
  1. trap: pc<=TRAP_VECTOR, epc<=pc, no retire, -> FLUSH.
  2. stall: pc, epc, instret held, stay RUN; jmp/br_taken this cycle are dropped and must be re-presented by the source.
  3. jmp: target = jmp_target.
  4. br_taken: target = br_target. jmp wins when both are set.
  5. Otherwise: pc<=pc_plus, instret+1, stay RUN.
- Redirect (3/4): misaligned when target[1:0]!=0 (C_EXT=0) or target[0]!=0 (C_EXT=1).
  - Aligned: pc<=target, instret+1, -> FLUSH.
  - Misaligned: pc<=TRAP_VECTOR, epc<=pc, misalign=1 for exactly the next cycle, no retire, -> FLUSH.
- FLUSH: pc held, pc_valid=0, all inputs including trap and stall ignored, no retire; next state RUN. Redirect-to-valid-fetch latency is 2 cycles.
- misalign is 0 in every cycle other than the one following a misaligned redirect.
- instret wraps from 2^CNT_W-1 to 0 without a flag.
- In RUN, the target value is ignored whenever its qualifier (jmp or br_taken) is low.

Test Plan:
1. Reset then free run: rst=1 for 2 cycles, then rst=0 -> pc=0 with pc_valid=0 for 1 cycle (BOOT); then pc=0,4,8,C with pc_valid=1; instret=1,2,3.
2. Stall and wrap: at pc=8, stall=1 for 3 cycles -> pc stays 8 and instret unchanged. Separate run with RESET_VECTOR=0xFFFF_FFF8 -> pc=FFFF_FFF8, FFFF_FFFC, 0000_0000.
3. Jump beats branch: at pc=0x10, jmp=1 with jmp_target=0x40 and br_taken=1 with br_target=0x80 -> next pc=0x40 with pc_valid=0 for 1 cycle (FLUSH); then pc=0x40, 0x44 with pc_valid=1.
4. Misaligned target: C_EXT=0 at pc=0x20, br_taken=1 with br_target=0x22 -> misalign=1 for 1 cycle, epc=0x20, pc=0x100, instret not incremented. Same target with C_EXT=1 -> pc=0x22, no misalign.
5. Compressed increment: C_EXT=1 at pc=0x100 with inst_is_c=1 -> pc_plus=0x102 and next pc=0x102; with inst_is_c=0 -> pc_plus=0x106, next pc=0x106.
6. Trap priority and mid-run reset: at pc=0x30, trap=1, stall=1 and jmp=1 together -> epc=0x30, pc=0x100, FLUSH; trap asserted during FLUSH is ignored. rst=1 during FLUSH -> pc=0, instret=0, state BOOT next cycle.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter unit. Holds the architectural PC and selects
//                the next PC each cycle: sequential (+4, or +2 for compressed
//                instructions), jump target, branch target or trap vector.
//                Also provides stall, a one-cycle redirect bubble, target
//                misalignment detection, exception PC capture and a
//                retired-instruction counter.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                stall                    - hold PC, no retire
//                inst_is_c                - current instruction is 16-bit
//                br_taken / br_target     - resolved taken branch + target
//                jmp / jmp_target         - unconditional jump + target
//                trap                     - trap request
//                pc / pc_plus             - fetch address / link value
//                pc_valid                 - pc is a valid fetch address
//                misalign                 - one-cycle misaligned-redirect pulse
//                epc                      - PC of trapping instruction
//                instret                  - retired-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
   parameter int                   XLEN         = 32,
   parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
   parameter int                   C_EXT        = 0,
   parameter int                   CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             inst_is_c,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_target,
   input  logic             jmp,
   input  logic [XLEN-1:0]  jmp_target,
   input  logic             trap,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus,
   output logic             pc_valid,
   output logic             misalign,
   output logic [XLEN-1:0]  epc,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t            state_q,    state_d;
   logic [XLEN-1:0]   pc_q,       pc_d;
   logic [XLEN-1:0]   epc_q,      epc_d;
   logic [CNT_W-1:0]  instret_q,  instret_d;
   logic              misalign_q, misalign_d;

   logic [XLEN-1:0]   w_inc;
   logic [XLEN-1:0]   w_target;
   logic              w_target_bad;

   // Compressed increment only exists when the C extension is built in.
   assign w_inc    = ((C_EXT != 0) && inst_is_c) ? XLEN'(2) : XLEN'(4);
   assign pc_plus  = pc_q + w_inc;

   // Jump outranks branch when both are presented in the same cycle.
   assign w_target = jmp ? jmp_target : br_target;

   // Halfword alignment suffices with compressed support, word otherwise.
   assign w_target_bad = (C_EXT != 0) ? w_target[0] : (|w_target[1:0]);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      instret_d  = instret_q;
      misalign_d = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (trap) begin
               pc_d    = TRAP_VECTOR;
               epc_d   = pc_q;
               state_d = ST_FLUSH;
            end else if (!stall) begin
               if (jmp || br_taken) begin
                  state_d = ST_FLUSH;
                  if (w_target_bad) begin
                     // Redirect to a misaligned target becomes a trap and
                     // the redirecting instruction does not retire.
                     pc_d       = TRAP_VECTOR;
                     epc_d      = pc_q;
                     misalign_d = 1'b1;
                  end else begin
                     pc_d      = w_target;
                     instret_d = instret_q + CNT_W'(1);
                  end
               end else begin
                  pc_d      = pc_plus;
                  instret_d = instret_q + CNT_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            // Bubble after any redirect: everything, including trap, ignored.
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         instret_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         instret_q  <= instret_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = (state_q == ST_RUN);
   assign misalign = misalign_q;
   assign epc      = epc_q;
   assign instret  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit. Three instances share one
//                stimulus stream: word-aligned (C_EXT=0), compressed
//                (C_EXT=1) and a near-top reset vector with a 4-bit retire
//                counter. A behavioural model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

   localparam logic [31:0] C_TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall, inst_is_c, br_taken, jmp, trap;
   logic [31:0] br_target, jmp_target;

   logic [31:0] pc0, pcp0, epc0, ir0;
   logic [31:0] pc1, pcp1, epc1, ir1;
   logic [31:0] pc2, pcp2, epc2;
   logic [3:0]  ir2;
   logic        v0, v1, v2, m0, m1, m2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(C_TV), .C_EXT(0), .CNT_W(32)) u_dut0 (
      .clk(clk), .rst(rst), .stall(stall), .inst_is_c(inst_is_c),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .trap(trap), .pc(pc0), .pc_plus(pcp0), .pc_valid(v0), .misalign(m0),
      .epc(epc0), .instret(ir0));

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(C_TV), .C_EXT(1), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst(rst), .stall(stall), .inst_is_c(inst_is_c),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .trap(trap), .pc(pc1), .pc_plus(pcp1), .pc_valid(v1), .misalign(m1),
      .epc(epc1), .instret(ir1));

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .TRAP_VECTOR(C_TV), .C_EXT(0), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst(rst), .stall(stall), .inst_is_c(inst_is_c),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .trap(trap), .pc(pc2), .pc_plus(pcp2), .pc_valid(v2), .misalign(m2),
      .epc(epc2), .instret(ir2));

   // Reference model state, one slot per instance.
   bit          cfg_c  [3] = '{1'b0, 1'b1, 1'b0};
   logic [31:0] cfg_rv [3] = '{32'h0, 32'h0, 32'hFFFF_FFF8};
   int          cfg_cw [3] = '{32, 32, 4};

   logic [31:0] m_pc  [3];
   logic [31:0] m_epc [3];
   logic [31:0] m_cnt [3];
   bit          m_mis [3];
   bit          m_dead[3];   // 1 = this cycle is a bubble (boot or post-redirect)

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt_mask(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

   function automatic logic [31:0] step_of(input int k);
      return (cfg_c[k] && inst_is_c) ? 32'd2 : 32'd4;
   endfunction

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_step();
      logic [31:0] t;
      bit          bad;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_pc[k] = cfg_rv[k]; m_epc[k] = 0; m_cnt[k] = 0;
            m_mis[k] = 0; m_dead[k] = 1;
         end else if (m_dead[k]) begin
            m_dead[k] = 0; m_mis[k] = 0;
         end else begin
            m_mis[k] = 0;
            if (trap) begin
               m_epc[k] = m_pc[k]; m_pc[k] = C_TV; m_dead[k] = 1;
            end else if (stall) begin
               // nothing moves
            end else if (jmp || br_taken) begin
               t   = jmp ? jmp_target : br_target;
               bad = cfg_c[k] ? (t % 2 != 0) : (t % 4 != 0);
               m_dead[k] = 1;
               if (bad) begin
                  m_epc[k] = m_pc[k]; m_pc[k] = C_TV; m_mis[k] = 1;
               end else begin
                  m_pc[k]  = t;
                  m_cnt[k] = (m_cnt[k] + 1) & cnt_mask(cfg_cw[k]);
               end
            end else begin
               m_pc[k]  = m_pc[k] + step_of(k);
               m_cnt[k] = (m_cnt[k] + 1) & cnt_mask(cfg_cw[k]);
            end
         end
      end
   endtask

   task automatic check_one(input int k, input logic [31:0] pc, input logic [31:0] pcp,
                            input logic vld, input logic mis, input logic [31:0] epc,
                            input logic [31:0] cnt);
      chk($sformatf("d%0d_pc", k),       pc,  m_pc[k]);
      chk($sformatf("d%0d_pc_plus", k),  pcp, m_pc[k] + step_of(k));
      chk($sformatf("d%0d_pc_valid", k), {31'd0, vld}, {31'd0, ~m_dead[k]});
      chk($sformatf("d%0d_misalign", k), {31'd0, mis}, {31'd0, m_mis[k]});
      chk($sformatf("d%0d_epc", k),      epc, m_epc[k]);
      chk($sformatf("d%0d_instret", k),  cnt, m_cnt[k]);
   endtask

   task automatic check_all();
      check_one(0, pc0, pcp0, v0, m0, epc0, ir0);
      check_one(1, pc1, pcp1, v1, m1, epc1, ir1);
      check_one(2, pc2, pcp2, v2, m2, epc2, {28'd0, ir2});
   endtask

   // One clock: drive on the falling edge, compare, then let the edge happen.
   task automatic cycle(input bit r, input bit s, input bit c, input bit b,
                        input logic [31:0] bt, input bit j, input logic [31:0] jt,
                        input bit t);
      @(negedge clk);
      rst = r; stall = s; inst_is_c = c; br_taken = b; br_target = bt;
      jmp = j; jmp_target = jt; trap = t;
      #1 check_all();
      @(posedge clk);
      model_step();
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
   endtask

   initial begin
      rst = 1; stall = 0; inst_is_c = 0; br_taken = 0; jmp = 0; trap = 0;
      br_target = 0; jmp_target = 0;
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      #1;
      chk("boot_pc",    pc0, 32'h0);
      chk("boot_valid", {31'd0, v0}, 32'd0);
      chk("boot_pc_hi", pc2, 32'hFFFF_FFF8);

      idle(); #1;
      chk("run_pc0",    pc0, 32'h0);
      chk("run_valid",  {31'd0, v0}, 32'd1);
      idle(); #1;
      chk("run_pc4",    pc0, 32'h4);
      chk("run_ir1",    ir0, 32'd1);
      chk("wrap_fffc",  pc2, 32'hFFFF_FFFC);
      idle(); #1;
      chk("run_pc8",    pc0, 32'h8);
      chk("wrap_zero",  pc2, 32'h0);
      repeat (3) cycle(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
      #1;
      chk("stall_pc",   pc0, 32'h8);
      chk("stall_ir",   ir0, 32'd2);
      idle(); idle(); #1;
      chk("pre_jmp_pc", pc0, 32'h10);

      cycle(0, 0, 0, 1, 32'h80, 1, 32'h40, 0); #1;
      chk("jmp_pc",     pc0, 32'h40);
      chk("jmp_flush",  {31'd0, v0}, 32'd0);
      idle(); #1;
      chk("jmp_valid",  {31'd0, v0}, 32'd1);
      idle(); #1;
      chk("jmp_pc44",   pc0, 32'h44);

      cycle(0, 0, 0, 1, 32'h22, 0, 32'h0, 0); #1;
      chk("mis_flag",   {31'd0, m0}, 32'd1);
      chk("mis_epc",    epc0, 32'h44);
      chk("mis_pc",     pc0, 32'h100);
      chk("mis_ir",     ir0, 32'd6);
      chk("c_pc",       pc1, 32'h22);
      chk("c_nomis",    {31'd0, m1}, 32'd0);
      idle(); #1;
      chk("mis_clear",  {31'd0, m0}, 32'd0);

      cycle(0, 0, 1, 0, 32'h0, 0, 32'h0, 0); #1;
      chk("c_inc2",     pc1, 32'h24);
      chk("nc_inc4",    pc0, 32'h104);
      cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 0); #1;
      chk("c_inc4",     pc1, 32'h28);

      cycle(0, 1, 0, 0, 32'h0, 1, 32'h200, 1); #1;
      chk("trap_epc",   epc0, 32'h108);
      chk("trap_pc",    pc0, 32'h100);
      cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 1); #1;
      chk("flush_trap", {31'd0, v0}, 32'd1);
      chk("flush_epc",  epc0, 32'h108);
      cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
      cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0); #1;
      chk("rst_pc",     pc0, 32'h0);
      chk("rst_ir",     ir0, 32'd0);
      chk("rst_valid",  {31'd0, v0}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] bt, jt;
         bt = $urandom; jt = $urandom;
         if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
         cycle($urandom_range(0, 63) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0, bt,
               $urandom_range(0, 7) == 0, jt,
               $urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      #1 check_all();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
